// File: rtl/clarke_park_seq_pkg.sv
// clarke_park_seq_pkg: shared vector-control word format, Clarke constants, sequencer states, sign-magnitude add
package clarke_park_seq_pkg;
  localparam int N = 24;
  localparam int Q = 12;
  localparam logic [N-1:0] K1_INV_SQRT3 = 24'h00093D;
  localparam logic [N-1:0] K2_2_INV_SQRT3 = 24'h00127A;
  localparam logic [N-2:0] SM_MAX_MAG = 23'h7FFFFF;
  typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, M4, M5} state_t;
  typedef struct packed {
    logic sat;
    logic [N-1:0] val;
  } sm_res_t;
  // Opposite signs subtract the smaller magnitude from the larger and can never overflow.
  function automatic sm_res_t sm_add_sat(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] sum;
    logic [N-2:0] mag;
    logic sgn;
    logic ovf;
    sum = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
    ovf = (a[N-1] == b[N-1]) & sum[N-1];
    sgn = a[N-1];
    mag = ovf ? SM_MAX_MAG : sum[N-2:0];
    if (a[N-1] != b[N-1]) begin
      sgn = (a[N-2:0] >= b[N-2:0]) ? a[N-1] : b[N-1];
      mag = (a[N-2:0] >= b[N-2:0]) ? a[N-2:0] - b[N-2:0] : b[N-2:0] - a[N-2:0];
    end
    return {ovf, sgn & |mag, mag};
  endfunction
endpackage

// File: rtl/sm_mul_sat.sv
// sm_mul_sat: combinational sign-magnitude Q12.12 multiply, truncating, saturating, no -0
// ports: i_a, i_b operands; o_p product; o_sat high when the magnitude overflowed
module sm_mul_sat
  import clarke_park_seq_pkg::*;
(
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_p,
  output logic         o_sat
);
  logic [2*N-3:0] w_full;
  logic [N-2:0] w_mag;
  always_comb begin
    w_full = {{(N-1){1'b0}}, i_a[N-2:0]} * {{(N-1){1'b0}}, i_b[N-2:0]};
    o_sat = |w_full[2*N-3:Q+N-1];
    w_mag = o_sat ? SM_MAX_MAG : w_full[Q+N-2:Q];
    o_p = {(i_a[N-1] ^ i_b[N-1]) & |w_mag, w_mag};
  end
endmodule

// File: rtl/clarke_park_seq.sv
// clarke_park_seq: Ia/Ib to rotor-frame Id/Iq through one shared saturating multiplier and a 7-state sequencer
// ports: clk, reset (async, high), start; Ia/Ib/SinQ/CosQ in; Id/Iq registered out, busy, done pulse, sticky sat
module clarke_park_seq
  import clarke_park_seq_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] Ia,
  input  logic [N-1:0] Ib,
  input  logic [N-1:0] SinQ,
  input  logic [N-1:0] CosQ,
  output logic [N-1:0] Id,
  output logic [N-1:0] Iq,
  output logic         busy,
  output logic         done,
  output logic         sat
);
  state_t r_state, w_next;
  logic [N-1:0] r_ia, r_ib, r_sin, r_cos, r_acc, r_ibeta, r_id;
  logic [N-1:0] w_ma, w_mb, w_p, w_addend;
  logic w_msat, w_add;
  sm_res_t w_sum;
  always_comb begin
    w_ma = (r_state == M1) ? r_ib : (r_state == M3 || r_state == M5) ? r_ibeta : r_ia;
    w_mb = (r_state == M1) ? K2_2_INV_SQRT3 :
           (r_state == M2 || r_state == M5) ? r_cos :
           (r_state == M3 || r_state == M4) ? r_sin : K1_INV_SQRT3;
    // M5 subtracts Ialpha*SinQ by flipping the accumulator sign
    w_addend = (r_state == M5) ? {~r_acc[N-1], r_acc[N-2:0]} : r_acc;
    w_sum = sm_add_sat(w_p, w_addend);
    w_add = (r_state == M1 || r_state == M3 || r_state == M5);
  end
  sm_mul_sat u_mul (.i_a(w_ma), .i_b(w_mb), .o_p(w_p), .o_sat(w_msat));
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = start ? M0 : IDLE;
      M0: w_next = M1;
      M1: w_next = M2;
      M2: w_next = M3;
      M3: w_next = M4;
      M4: w_next = M5;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ia <= '0;
      r_ib <= '0;
      r_sin <= '0;
      r_cos <= '0;
      r_acc <= '0;
      r_ibeta <= '0;
      r_id <= '0;
      Id <= '0;
      Iq <= '0;
      done <= 1'b0;
      sat <= 1'b0;
    end else begin
      done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_ia <= Ia;
          r_ib <= Ib;
          r_sin <= SinQ;
          r_cos <= CosQ;
          sat <= 1'b0;
        end
      end else sat <= sat | w_msat | (w_add & w_sum.sat);
      if (r_state == M0 || r_state == M2 || r_state == M4) r_acc <= w_p;
      if (r_state == M1) r_ibeta <= w_sum.val;
      if (r_state == M3) r_id <= w_sum.val;
      if (r_state == M5) begin
        Id <= r_id;
        Iq <= w_sum.val;
        done <= 1'b1;
      end
    end
  end
  assign busy = (r_state != IDLE);
endmodule

// File: tb/tb_clarke_park_seq.sv
// tb_clarke_park_seq: directed and reference-model checks of clarke_park_seq
module tb_clarke_park_seq;
  logic clk = 1'b0;
  logic reset, start;
  logic [23:0] Ia, Ib, SinQ, CosQ, Id, Iq;
  logic busy, done, sat;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  clarke_park_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .Ia(Ia), .Ib(Ib), .SinQ(SinQ), .CosQ(CosQ),
    .Id(Id), .Iq(Iq), .busy(busy), .done(done), .sat(sat)
  );
  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [24:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
    logic [63:0] p;
    logic [63:0] t;
    logic [22:0] m;
    logic s;
    p = {41'b0, a[22:0]} * {41'b0, b[22:0]};
    t = p >> 12;
    s = t > 64'h7FFFFF;
    m = s ? 23'h7FFFFF : t[22:0];
    return {s, (a[23] ^ b[23]) && (m != 0), m};
  endfunction
  function automatic logic [24:0] ref_add(input logic [23:0] a, input logic [23:0] b, input logic neg);
    longint va, vb, sm, mg;
    logic [22:0] m;
    logic s;
    va = longint'({41'b0, a[22:0]});
    vb = longint'({41'b0, b[22:0]});
    if (a[23]) va = -va;
    if (b[23] ^ neg) vb = -vb;
    sm = va + vb;
    mg = (sm < 0) ? -sm : sm;
    s = mg > 64'sh7FFFFF;
    m = s ? 23'h7FFFFF : mg[22:0];
    return {s, (sm < 0) && (m != 0), m};
  endfunction
  task automatic ref_conv(input logic [23:0] ia, ib, sq, cq, output logic [23:0] eid, eiq, output logic esat);
    logic [24:0] acc, p, ibeta, x, y;
    acc = ref_mul(ia, 24'h00093D);
    p = ref_mul(ib, 24'h00127A);
    ibeta = ref_add(acc[23:0], p[23:0], 1'b0);
    esat = acc[24] | p[24] | ibeta[24];
    x = ref_mul(ia, cq);
    y = ref_mul(ibeta[23:0], sq);
    acc = ref_add(x[23:0], y[23:0], 1'b0);
    esat = esat | x[24] | y[24] | acc[24];
    eid = acc[23:0];
    x = ref_mul(ia, sq);
    y = ref_mul(ibeta[23:0], cq);
    acc = ref_add(y[23:0], x[23:0], 1'b1);
    esat = esat | x[24] | y[24] | acc[24];
    eiq = acc[23:0];
  endtask
  task automatic run_conv(input string tag, input logic [23:0] ia, ib, sq, cq, eid, eiq, input logic esat);
    @(negedge clk);
    Ia = ia; Ib = ib; SinQ = sq; CosQ = cq; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check($sformatf("%s.busy_e0", tag), busy, 1);
    repeat (5) @(posedge clk);
    #1 check($sformatf("%s.done_e5", tag), done, 0);
    check($sformatf("%s.busy_e5", tag), busy, 1);
    @(posedge clk); #1;
    check($sformatf("%s.done_e6", tag), done, 1);
    check($sformatf("%s.busy_e6", tag), busy, 0);
    check($sformatf("%s.id", tag), Id, eid);
    check($sformatf("%s.iq", tag), Iq, eiq);
    check($sformatf("%s.sat", tag), sat, esat);
    @(posedge clk); #1 check($sformatf("%s.done_e7", tag), done, 0);
  endtask
  function automatic logic [23:0] rnd();
    return {1'($urandom_range(0, 1)), 23'($urandom_range(0, 'hFFFFF))};
  endfunction
  initial begin
    int nd;
    int pos[4];
    logic [23:0] a, b, s, c, eid, eiq;
    logic es;
    reset = 1'b1; start = 1'b0; Ia = '0; Ib = '0; SinQ = '0; CosQ = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.id", Id, 0); check("rst.iq", Iq, 0); check("rst.busy", busy, 0);
    check("rst.done", done, 0); check("rst.sat", sat, 0);
    @(negedge clk) reset = 1'b0;
    run_conv("t1", 24'h001000, 24'h000000, 24'h000000, 24'h001000, 24'h001000, 24'h00093D, 1'b0);
    run_conv("t2", 24'h001000, 24'h800800, 24'h001000, 24'h000000, 24'h000000, 24'h801000, 1'b0);
    run_conv("t3", 24'h3FF000, 24'h3FF000, 24'h001000, 24'h001000, 24'h7FFFFF, 24'h2ED049, 1'b1);
    run_conv("satclr", 24'h001000, 24'h000000, 24'h000000, 24'h001000, 24'h001000, 24'h00093D, 1'b0);
    // start held for 20 edges: accepted at E0, E7, E14 only
    @(negedge clk);
    Ia = 24'h001000; Ib = 24'h000000; SinQ = 24'h000000; CosQ = 24'h001000; start = 1'b1;
    nd = 0;
    for (int i = 0; i < 4; i++) pos[i] = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 19) start = 1'b0;
      if (done) begin
        if (nd < 4) pos[nd] = i;
        nd++;
      end
    end
    check("b2b.count", nd, 3);
    check("b2b.pos0", pos[0], 6);
    check("b2b.pos1", pos[1], 13);
    check("b2b.pos2", pos[2], 20);
    check("b2b.id", Id, 24'h001000);
    // start and new inputs during M2 must not disturb the running conversion
    @(negedge clk);
    Ia = 24'h001000; Ib = 24'h800800; SinQ = 24'h001000; CosQ = 24'h000000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; Ia = 24'h3FF000; Ib = 24'h3FF000; SinQ = 24'h001000; CosQ = 24'h001000;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("m2.done", done, 1);
    check("m2.id", Id, 24'h000000);
    check("m2.iq", Iq, 24'h801000);
    check("m2.sat", sat, 0);
    @(posedge clk); #1 check("m2.noqueue", busy, 0);
    // reset asserted while in M3
    @(negedge clk);
    Ia = 24'h3FF000; Ib = 24'h3FF000; SinQ = 24'h001000; CosQ = 24'h001000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("m3.busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    check("m3rst.busy", busy, 0); check("m3rst.done", done, 0);
    check("m3rst.id", Id, 0); check("m3rst.iq", Iq, 0); check("m3rst.sat", sat, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("m3rst.nodone", nd, 0);
    run_conv("postrst", 24'h001000, 24'h000000, 24'h000000, 24'h001000, 24'h001000, 24'h00093D, 1'b0);
    for (int k = 0; k < 1000; k++) begin
      a = rnd(); b = rnd(); s = rnd(); c = rnd();
      ref_conv(a, b, s, c, eid, eiq, es);
      run_conv($sformatf("rnd%0d", k), a, b, s, c, eid, eiq, es);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
